invntt_sched: RTL and testbench
===============================

# invntt_sched

Job scheduler sharing one inverse-NTT core (readin/compute/readout FSM plus ping-pong RAMs) among NREQ polynomial requesters. It arbitrates round-robin, sequences the core's readin, compute and readout handshakes for the winning requester, and reports completion. It guards every phase with a timeout that resets the core on a hang. It sits between the per-polynomial request logic and the core; the coefficient data mux is steered by `grant`/`grant_id` outside this block.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 1024: maximum cycles per phase before abort (must be < 2^16).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `req` in NREQ: level request per requester.
- `grant` out NREQ: one-hot owner of the core, 0 when idle.
- `grant_id` out $clog2(NREQ): index of the owner, 0 when idle.
- `job_done` out NREQ: one-cycle pulse on the owner's bit at job completion.
- `err` out 1: one-cycle pulse on timeout abort; `grant_id` is still valid in that cycle.
- `busy` out 1: high from grant until return to IDLE.
- `core_set` out 1: core enable, high whenever `reset`=1.
- `core_rst` out 1: active-high core reset pulse.
- `core_readin`, `core_cal_en`, `core_readout` out 1 each: core phase commands.
- `core_readin_ok`, `core_full_in`, `core_full_out`, `core_done` in 1 each: core status.

## Operation
- States: IDLE, ARB, LOAD, CALC, DRAIN, RELEASE, ABORT.
- IDLE: if any `req`, go to ARB.
- ARB: one cycle. Pick the first asserted `req` at or after `rr_ptr`, wrapping around. Register `grant`/`grant_id`, then go to LOAD. If `req` has dropped to 0, return to IDLE.
- LOAD:
  - `core_readin`=1 until `core_readin_ok`=1 has been seen.
  - Then hold `core_readin` at 0 and wait for `core_full_in`=1.
  - On `core_full_in`=1, go to CALC.
- CALC: `core_cal_en`=1 continuously until `core_done`=1, then go to DRAIN.
- DRAIN: `core_readout`=1 until `core_full_out`=1, then go to RELEASE.
- RELEASE:
  - Pulse `job_done[grant_id]` in the first cycle only.
  - Set `rr_ptr` = (grant_id+1) mod NREQ.
  - Wait for `core_done`=0, then clear the grant and go to IDLE.
- Timeout:
  - Phase counter (16 bit) clears on every state entry and increments each cycle in LOAD/CALC/DRAIN/RELEASE.
  - When it reaches TIMEOUT-1, go to ABORT.
- ABORT:
  - Two cycles, with `core_rst`=1 in both.
  - `err` pulses in the first cycle.
  - `rr_ptr` advances past the aborted owner.
  - Grant clears on exit, then go to IDLE.
  - No `job_done` is issued.
- Request changes after ARB are ignored; the grant holds until RELEASE or ABORT completes.
- A `req` arriving during a job is served in a later ARB.
- Only one core command is high in any cycle.

## Timing
- Reset (`reset`=0 at a clock edge) forces:
  - state IDLE, `rr_ptr`=0;
  - outputs `grant`=0, `grant_id`=0, `job_done`=0, `err`=0, `busy`=0, `core_set`=0, `core_rst`=1, all core commands 0.
- The first cycle after reset release has `core_rst`=0 and `core_set`=1.
- Reset mid-job aborts silently, with no `err` or `job_done`.
- All outputs are registered.
- `req`→`grant` latency is 2 cycles (IDLE→ARB→grant visible).
- Status inputs act in the cycle after they are sampled: a status high at edge n gives the command change at edge n+1.
- Minimum job overhead is 5 cycles beyond the core's own latency.

## Structure
- Shared package `kyber_ctrl_pkg` holds:
  - the state encoding (one-hot, 7 bits);
  - the default TIMEOUT;
  - a `clog2`-based ID width function, shared by the other schedulers.
- One sub-module, `rr_arbiter`:
  - combinational first-set search from a pointer, with wrap-around;
  - ports `req`, `ptr` in; `gnt_onehot`, `gnt_id`, `any` out.
- The FSM, counters and `rr_ptr` stay in `invntt_sched`.

## Test plan
- Reset release with `req`=0 → all outputs 0, `core_set`=1, state remains IDLE for 100 cycles.
- `req`=4'b0100 with a behavioural core model → `grant`=4'b0100, `grant_id`=2 two cycles later. `core_readin`, then `core_cal_en`, then `core_readout` assert in order. `job_done`=4'b0100 pulses once; `busy` falls after `core_done`=0.
- `req`=4'b1111 held for 4 jobs → grant order 0,1,2,3, then 0 again; `rr_ptr` wraps around 3→0.
- Core model never raises `core_done` in CALC, TIMEOUT=64 → `err` pulses 64 cycles after CALC entry, `core_rst` high for 2 cycles, no `job_done`, next grant goes to the following requester.
- Owner drops `req` during LOAD while requester 3 raises `req` → current job completes with `job_done`, then requester 3 is granted.
- `reset`=0 asserted during DRAIN → next cycle all outputs are at reset values; after release, a fresh `req`=4'b0001 runs a full job normally.

Source files
------------

// File: rtl/kyber_ctrl_pkg.sv
// ============================================================================
// Module      : kyber_ctrl_pkg
// Description : Shared definitions for the Kyber core schedulers: one-hot
//               scheduler state encoding, default phase timeout and the
//               requester-ID width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kyber_ctrl_pkg;

  // Default per-phase cycle limit before a job is aborted
  localparam int TIMEOUT_DEFAULT = 1024;

  // One-hot scheduler states
  typedef enum logic [6:0] {
    S_IDLE    = 7'b000_0001,
    S_ARB     = 7'b000_0010,
    S_LOAD    = 7'b000_0100,
    S_CALC    = 7'b000_1000,
    S_DRAIN   = 7'b001_0000,
    S_RELEASE = 7'b010_0000,
    S_ABORT   = 7'b100_0000
  } sched_state_t;

  // Width of a requester index; never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first asserted request at or
//               after the pointer, wrapping around.
// Ports       : req        in  NREQ  request vector
//               ptr        in  IDW   search start index
//               gnt_onehot out NREQ  one-hot winner (0 if none)
//               gnt_id     out IDW   winner index (0 if none)
//               any        out 1     at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  logic [IDW-1:0] sel;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    sel        = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel = IDW'((int'(ptr) + i) % NREQ);
      if (!any && req[sel]) begin
        any             = 1'b1;
        gnt_onehot[sel] = 1'b1;
        gnt_id          = sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/invntt_sched.sv
// ============================================================================
// Module      : invntt_sched
// Description : Round-robin job scheduler sharing one inverse-NTT core among
//               NREQ requesters. Sequences readin / compute / readout, pulses
//               completion, and aborts (core reset) on a per-phase timeout.
// Ports       : clk, reset (sync, active-low)
//               req[NREQ]          level requests
//               grant[NREQ], grant_id  current owner (0 when idle)
//               job_done[NREQ]     completion pulse on owner bit
//               err                timeout-abort pulse
//               busy               owner present
//               core_set, core_rst core enable / reset
//               core_readin, core_cal_en, core_readout   phase commands
//               core_readin_ok, core_full_in, core_full_out, core_done  status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module invntt_sched
  import kyber_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  output logic [NREQ-1:0]           grant,
  output logic [id_width(NREQ)-1:0] grant_id,
  output logic [NREQ-1:0]           job_done,
  output logic                      err,
  output logic                      busy,
  output logic                      core_set,
  output logic                      core_rst,
  output logic                      core_readin,
  output logic                      core_cal_en,
  output logic                      core_readout,
  input  logic                      core_readin_ok,
  input  logic                      core_full_in,
  input  logic                      core_full_out,
  input  logic                      core_done
);

  localparam int IDW = id_width(NREQ);

  sched_state_t    state, state_nxt;
  logic [15:0]     cnt;
  logic [IDW-1:0]  rr_ptr;
  logic            readin_seen, readin_seen_nxt;
  logic            abort_2nd;
  logic            timeout_hit;
  logic            entering;
  logic            phase_st;
  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_id;
  logic            arb_any;
  logic [IDW-1:0]  ptr_inc;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (req),
    .ptr        (rr_ptr),
    .gnt_onehot (arb_gnt),
    .gnt_id     (arb_id),
    .any        (arb_any)
  );

  assign timeout_hit = (cnt == 16'(TIMEOUT - 1));
  assign ptr_inc     = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
  assign entering    = (state_nxt != state);
  assign phase_st    = (state == S_LOAD) || (state == S_CALC) ||
                       (state == S_DRAIN) || (state == S_RELEASE);

  // readin handshake flag lives only while LOAD persists
  assign readin_seen_nxt = (state == S_LOAD && state_nxt == S_LOAD) ?
                           (readin_seen | core_readin_ok) : 1'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (|req) state_nxt = S_ARB;
      S_ARB:     state_nxt = arb_any ? S_LOAD : S_IDLE;
      S_LOAD: begin
        // full_in only counts once the readin handshake has completed
        if (readin_seen && core_full_in) state_nxt = S_CALC;
        else if (timeout_hit)            state_nxt = S_ABORT;
      end
      S_CALC: begin
        if (core_done)        state_nxt = S_DRAIN;
        else if (timeout_hit) state_nxt = S_ABORT;
      end
      S_DRAIN: begin
        if (core_full_out)    state_nxt = S_RELEASE;
        else if (timeout_hit) state_nxt = S_ABORT;
      end
      S_RELEASE: begin
        if (!core_done)       state_nxt = S_IDLE;
        else if (timeout_hit) state_nxt = S_ABORT;
      end
      S_ABORT:   if (abort_2nd) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // All outputs are registered from the next-state decision so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      rr_ptr       <= '0;
      readin_seen  <= 1'b0;
      abort_2nd    <= 1'b0;
      grant        <= '0;
      grant_id     <= '0;
      job_done     <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      core_set     <= 1'b0;
      core_rst     <= 1'b1;
      core_readin  <= 1'b0;
      core_cal_en  <= 1'b0;
      core_readout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= (entering || !phase_st) ? 16'd0 : cnt + 16'd1;
      readin_seen <= readin_seen_nxt;
      abort_2nd   <= (state == S_ABORT) && (state_nxt == S_ABORT);

      if (state == S_ARB && arb_any) begin
        grant    <= arb_gnt;
        grant_id <= arb_id;
      end else if (state_nxt == S_IDLE) begin
        grant    <= '0;
        grant_id <= '0;
      end

      if (entering && (state_nxt == S_RELEASE || state_nxt == S_ABORT))
        rr_ptr <= ptr_inc;

      job_done     <= (entering && state_nxt == S_RELEASE) ? grant : '0;
      err          <= entering && (state_nxt == S_ABORT);
      busy         <= !(state_nxt == S_IDLE || state_nxt == S_ARB);
      core_set     <= 1'b1;
      core_rst     <= (state_nxt == S_ABORT);
      core_readin  <= (state_nxt == S_LOAD) && !readin_seen_nxt;
      core_cal_en  <= (state_nxt == S_CALC);
      core_readout <= (state_nxt == S_DRAIN);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_invntt_sched.sv
// ============================================================================
// Module      : tb_invntt_sched
// Description : Self-checking bench for invntt_sched with a behavioural
//               inverse-NTT core model and an expected-owner scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_invntt_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       core_readin_ok = 1'b0;
  logic       core_full_in = 1'b0;
  logic       core_full_out = 1'b0;
  logic       core_done = 1'b0;

  logic [3:0] grant;
  logic [1:0] grant_id;
  logic [3:0] job_done;
  logic       err, busy, core_set, core_rst;
  logic       core_readin, core_cal_en, core_readout;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit hang = 1'b0;

  invntt_sched #(.NREQ(4), .TIMEOUT(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .grant          (grant),
    .grant_id       (grant_id),
    .job_done       (job_done),
    .err            (err),
    .busy           (busy),
    .core_set       (core_set),
    .core_rst       (core_rst),
    .core_readin    (core_readin),
    .core_cal_en    (core_cal_en),
    .core_readout   (core_readout),
    .core_readin_ok (core_readin_ok),
    .core_full_in   (core_full_in),
    .core_full_out  (core_full_out),
    .core_done      (core_done)
  );

  always #5 clk = ~clk;

  // Behavioural core: readin_ok after 2 readin cycles, full_in 3 cycles later,
  // done after 5 cal_en cycles (held), full_out after 3 readout cycles, done
  // drops 2 cycles after full_out.
  int rd_cnt = 0, ld_cnt = 0, cal_cnt = 0, out_cnt = 0, post_cnt = 0;
  bit loading = 1'b0, posting = 1'b0;

  always @(negedge clk) begin
    core_readin_ok = 1'b0;
    core_full_in   = 1'b0;
    core_full_out  = 1'b0;
    if (!reset || core_rst) begin
      core_done = 1'b0;
      rd_cnt = 0; ld_cnt = 0; cal_cnt = 0; out_cnt = 0; post_cnt = 0;
      loading = 1'b0; posting = 1'b0;
    end else begin
      if (core_readin) begin
        rd_cnt++;
        if (rd_cnt == 2) begin core_readin_ok = 1'b1; loading = 1'b1; ld_cnt = 0; end
      end else if (loading) begin
        ld_cnt++;
        if (ld_cnt == 3) begin core_full_in = 1'b1; loading = 1'b0; end
      end
      if (core_cal_en && !hang && !core_done) begin
        cal_cnt++;
        if (cal_cnt == 5) core_done = 1'b1;
      end
      if (core_readout) begin
        out_cnt++;
        if (out_cnt == 3) begin core_full_out = 1'b1; posting = 1'b1; post_cnt = 0; end
      end else if (posting) begin
        post_cnt++;
        if (post_cnt == 2) begin
          core_done = 1'b0; posting = 1'b0;
          rd_cnt = 0; cal_cnt = 0; out_cnt = 0;
        end
      end
    end
  end

  function automatic logic [18:0] pack_out();
    return {grant, grant_id, job_done, err, busy, core_set, core_rst,
            core_readin, core_cal_en, core_readout};
  endfunction

  function automatic bit sig_now(input int which);
    case (which)
      0:       return grant != 4'b0;
      1:       return job_done != 4'b0;
      2:       return err;
      3:       return !busy;
      4:       return core_readin;
      5:       return core_cal_en;
      6:       return core_readout;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sig_now(which)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [18:0] obs;
    bit idle_ok;
    reset = 1'b0; req = 4'b0;
    repeat (3) @(negedge clk);
    obs = pack_out();
    checks++;
    if (obs !== 19'b0000_00_0000_0_0_0_1_000) begin
      errors++; $display("FAIL reset_values: got %b expected %b", obs, 19'b0000_00_0000_0_0_0_1_000);
    end
    reset = 1'b1;
    @(negedge clk);
    obs = pack_out();
    checks++;
    if (obs !== 19'b0000_00_0000_0_0_1_0_000) begin
      errors++; $display("FAIL reset_release: got %b expected %b", obs, 19'b0000_00_0000_0_0_1_0_000);
    end
    idle_ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (pack_out() !== 19'b0000_00_0000_0_0_1_0_000) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin
      errors++; $display("FAIL idle_hold: got %b expected %b", pack_out(), 19'b0000_00_0000_0_0_1_0_000);
    end
  endtask

  task automatic test_single_job();
    int t_rd = -1, t_cal = -1, t_ro = -1, jd_cnt = 0, multi = 0, e;
    logic [3:0] jd_val = 4'b0;
    bit fell = 1'b0, err_seen = 1'b0;
    logic done_at_fall = 1'b1;
    @(negedge clk);
    req = 4'b0100;
    exp_q.push_back(2);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL grant_in_arb: got %b expected %b", grant, 4'b0000);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      errors++; $display("FAIL grant_latency: got %b/%0d expected 0100/2", grant, grant_id);
    end
    req = 4'b0000;
    for (int t = 0; t < 200; t++) begin
      if (core_readin && t_rd < 0) t_rd = t;
      if (core_cal_en && t_cal < 0) t_cal = t;
      if (core_readout && t_ro < 0) t_ro = t;
      if (job_done != 4'b0) begin jd_cnt++; jd_val = job_done; end
      if ($countones({core_readin, core_cal_en, core_readout}) > 1) multi++;
      if (err) err_seen = 1'b1;
      if (!busy) begin fell = 1'b1; done_at_fall = core_done; break; end
      @(negedge clk);
    end
    checks++;
    if (!(t_rd >= 0 && t_rd < t_cal && t_cal < t_ro)) begin
      errors++; $display("FAIL cmd_order: got rd=%0d cal=%0d ro=%0d expected increasing", t_rd, t_cal, t_ro);
    end
    checks++;
    if (multi != 0) begin
      errors++; $display("FAIL cmd_onehot: got %0d overlap cycles expected 0", multi);
    end
    checks++;
    if (!fell || done_at_fall !== 1'b0) begin
      errors++; $display("FAIL busy_fall: got fell=%0d done=%b expected fell=1 done=0", fell, done_at_fall);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++;
    if (jd_cnt != 1 || jd_val !== 4'(1 << e)) begin
      errors++; $display("FAIL single_job_done: got %0d pulses val %b expected 1 pulse val %b", jd_cnt, jd_val, 4'(1 << e));
    end
    checks++;
    if (err_seen || grant !== 4'b0) begin
      errors++; $display("FAIL single_job_end: got err=%0d grant=%b expected err=0 grant=0000", err_seen, grant);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int e;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int j = 0; j < 5; j++) begin
      wait_sig(1, 300, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      checks++;
      if (!ok || job_done !== 4'(1 << e) || grant_id !== 2'(e)) begin
        errors++; $display("FAIL rr_job%0d: got done=%b id=%0d expected done=%b id=%0d", j, job_done, grant_id, 4'(1 << e), e);
      end
      if (j == 4) req = 4'b0000;
    end
    wait_sig(3, 50, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rr_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_timeout();
    bit ok, jd_seen = 1'b0;
    int n = 0, rst_cnt = 0, e;
    logic [1:0] id_at_err;
    hang = 1'b1;
    @(negedge clk);
    req = 4'b0110;
    wait_sig(5, 100, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL to_calc_entry: got cal_en=%b expected 1", core_cal_en);
    end
    for (int i = 0; i < 200 && !err; i++) begin
      @(negedge clk);
      n++;
      if (job_done != 4'b0) jd_seen = 1'b1;
    end
    id_at_err = grant_id;
    checks++;
    if (!err || n != 64) begin
      errors++; $display("FAIL to_latency: got err=%b after %0d cycles expected 1 after 64", err, n);
    end
    checks++;
    if (id_at_err !== 2'd1) begin
      errors++; $display("FAIL to_grant_id: got %0d expected 1", id_at_err);
    end
    hang = 1'b0;
    for (int i = 0; i < 10 && core_rst; i++) begin
      rst_cnt++;
      if (job_done != 4'b0) jd_seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (rst_cnt != 2) begin
      errors++; $display("FAIL to_core_rst: got %0d cycles expected 2", rst_cnt);
    end
    exp_q.push_back(2);
    wait_sig(1, 300, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    req = 4'b0000;
    checks++;
    if (!ok || jd_seen || job_done !== 4'(1 << e)) begin
      errors++; $display("FAIL to_next_owner: got done=%b stray=%0d expected done=%b stray=0", job_done, jd_seen, 4'(1 << e));
    end
    wait_sig(3, 50, ok);
  endtask

  task automatic test_req_change();
    bit ok;
    int e;
    @(negedge clk);
    req = 4'b0001;
    exp_q.push_back(0); exp_q.push_back(3);
    wait_sig(4, 50, ok);
    req = 4'b1000;
    for (int j = 0; j < 2; j++) begin
      wait_sig(1, 300, ok);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      checks++;
      if (!ok || job_done !== 4'(1 << e) || grant_id !== 2'(e)) begin
        errors++; $display("FAIL req_change_job%0d: got done=%b id=%0d expected done=%b id=%0d", j, job_done, grant_id, 4'(1 << e), e);
      end
    end
    req = 4'b0000;
    wait_sig(3, 50, ok);
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    int e;
    logic [18:0] obs;
    @(negedge clk);
    req = 4'b0001;
    wait_sig(6, 100, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL mid_drain_reach: got readout=%b expected 1", core_readout);
    end
    reset = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    obs = pack_out();
    checks++;
    if (obs !== 19'b0000_00_0000_0_0_0_1_000) begin
      errors++; $display("FAIL mid_reset_values: got %b expected %b", obs, 19'b0000_00_0000_0_0_0_1_000);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    req = 4'b0001;
    exp_q.push_back(0);
    wait_sig(1, 300, ok);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    req = 4'b0000;
    checks++;
    if (!ok || job_done !== 4'(1 << e)) begin
      errors++; $display("FAIL post_reset_job: got done=%b expected %b", job_done, 4'(1 << e));
    end
    wait_sig(3, 50, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++; $display("FAIL final_idle: got busy=%b queue=%0d expected busy=0 queue=0", busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_timeout();
    test_req_change();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
